// File: rtl/ucdp_sync_leaf_one.sv
// Synchronizer leaf with reset value fixed to 1.
module ucdp_sync_leaf_one #(
   parameter int stages_p = 2,
   parameter int width_p  = 1
) (
   input  logic               main_clk_i,
   input  logic               main_rst_i,
   input  logic               scan_shift_i,
   input  logic [width_p-1:0] d_i,
   output logic [width_p-1:0] q_o
);

   ucdp_sync_leaf #(
      .rstval_p (1'b1),
      .stages_p (stages_p),
      .width_p  (width_p)
   ) u_leaf (
      .main_clk_i   (main_clk_i),
      .main_rst_i   (main_rst_i),
      .scan_shift_i (scan_shift_i),
      .d_i          (d_i),
      .q_o          (q_o)
   );

endmodule

// File: rtl/ucdp_sync_leaf_zero.sv
// Synchronizer leaf with reset value fixed to 0.
module ucdp_sync_leaf_zero #(
   parameter int stages_p = 2,
   parameter int width_p  = 1
) (
   input  logic               main_clk_i,
   input  logic               main_rst_i,
   input  logic               scan_shift_i,
   input  logic [width_p-1:0] d_i,
   output logic [width_p-1:0] q_o
);

   ucdp_sync_leaf #(
      .rstval_p (1'b0),
      .stages_p (stages_p),
      .width_p  (width_p)
   ) u_leaf (
      .main_clk_i   (main_clk_i),
      .main_rst_i   (main_rst_i),
      .scan_shift_i (scan_shift_i),
      .d_i          (d_i),
      .q_o          (q_o)
   );

endmodule

// File: rtl/ucdp_sync_leaf.sv
// Multi-flop CDC synchronizer leaf: a plain per-bit flop chain with an
// asynchronous reset that is gated off while scan shift is active.
module ucdp_sync_leaf #(
   parameter logic rstval_p = 1'b0,
   parameter int   stages_p = 2,
   parameter int   width_p  = 1
) (
   input  logic               main_clk_i,
   input  logic               main_rst_i,
   input  logic               scan_shift_i,
   input  logic [width_p-1:0] d_i,
   output logic [width_p-1:0] q_o
);

   if (stages_p < 2 || stages_p > 4) begin : g_bad_stages
      $error("ucdp_sync_leaf: stages_p must be in 2..4");
   end

   logic               rst_eff;
   logic [width_p-1:0] stage_q [stages_p];
   logic [width_p-1:0] stage_d [stages_p];

   // Scan shift must not be disturbed by a functional reset.
   assign rst_eff = main_rst_i & ~scan_shift_i;

   always_comb begin
      stage_d[0] = d_i;
      for (int i = 1; i < stages_p; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge main_clk_i or posedge rst_eff) begin
      if (rst_eff) begin
         for (int i = 0; i < stages_p; i++) begin
            stage_q[i] <= {width_p{rstval_p}};
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q_o = stage_q[stages_p-1];

endmodule

// File: tb/tb_ucdp_sync_leaf.sv
// Directed plus randomized bench for ucdp_sync_leaf against a delay-line model.
module tb_ucdp_sync_leaf;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scan = 1'b0;
   logic       d_zero = 1'b0;
   logic       d_one = 1'b0;
   logic [3:0] d_wide = 4'h0;
   logic       q_zero;
   logic       q_one;
   logic [3:0] q_wide;

   int checks = 0;
   int failures = 0;

   // Each queue holds the last N sampled inputs, oldest at the front;
   // the front is what the output must show.
   logic       mz[$];
   logic       mo[$];
   logic [3:0] mw[$];

   always #5 clk = ~clk;

   ucdp_sync_leaf #(.rstval_p(1'b0), .stages_p(2), .width_p(1)) u_zero (
      .main_clk_i(clk), .main_rst_i(rst), .scan_shift_i(scan), .d_i(d_zero), .q_o(q_zero));
   ucdp_sync_leaf #(.rstval_p(1'b1), .stages_p(2), .width_p(1)) u_one (
      .main_clk_i(clk), .main_rst_i(rst), .scan_shift_i(scan), .d_i(d_one), .q_o(q_one));
   ucdp_sync_leaf #(.rstval_p(1'b0), .stages_p(3), .width_p(4)) u_wide (
      .main_clk_i(clk), .main_rst_i(rst), .scan_shift_i(scan), .d_i(d_wide), .q_o(q_wide));

   task automatic reset_model();
      mz.delete();
      mo.delete();
      mw.delete();
      for (int i = 0; i < 2; i++) begin
         mz.push_back(1'b0);
         mo.push_back(1'b1);
      end
      for (int i = 0; i < 3; i++) mw.push_back(4'h0);
   endtask

   task automatic check_all(input string tag);
      checks++;
      assert (q_zero === mz[0]) else begin
         failures++;
         $error("FAIL %s_zero observed=%0b expected=%0b", tag, q_zero, mz[0]);
      end
      checks++;
      assert (q_one === mo[0]) else begin
         failures++;
         $error("FAIL %s_one observed=%0b expected=%0b", tag, q_one, mo[0]);
      end
      checks++;
      assert (q_wide === mw[0]) else begin
         failures++;
         $error("FAIL %s_wide observed=%h expected=%h", tag, q_wide, mw[0]);
      end
   endtask

   task automatic check1(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (!(rst && !scan)) begin
         mz.push_back(d_zero); void'(mz.pop_front());
         mo.push_back(d_one);  void'(mo.pop_front());
         mw.push_back(d_wide); void'(mw.pop_front());
      end
      #1;
      check_all(tag);
   endtask

   task automatic set_ctl(input logic r, input logic s);
      rst  = r;
      scan = s;
      #1;
      if (r && !s) reset_model();
      check_all("async");
   endtask

   initial begin
      reset_model();

      // Reset holds outputs at their reset values while d toggles.
      for (int i = 0; i < 4; i++) begin
         d_zero = ~d_zero;
         d_one  = ~d_one;
         d_wide = 4'($urandom);
         tick("in_rst");
      end
      check1("rst_zero", {3'b0, q_zero}, 4'h0);
      check1("rst_one", {3'b0, q_one}, 4'h1);
      check1("rst_wide", q_wide, 4'h0);

      // Release: latency on zero, mismatch on one, 3-stage wide bus.
      d_zero = 1'b0;
      d_one  = 1'b0;
      d_wide = 4'hA;
      set_ctl(1'b0, 1'b0);
      tick("rel1");
      check1("one_hold_e1", {3'b0, q_one}, 4'h1);
      check1("wide_e1", q_wide, 4'h0);
      d_zero = 1'b1;
      tick("rel2");
      check1("zero_edge_k", {3'b0, q_zero}, 4'h0);
      check1("one_fall_e2", {3'b0, q_one}, 4'h0);
      check1("wide_e2", q_wide, 4'h0);
      tick("rel3");
      check1("zero_edge_k1", {3'b0, q_zero}, 4'h1);
      check1("wide_e3", q_wide, 4'hA);
      d_zero = 1'b0;
      tick("fall1");
      check1("zero_fall_hold", {3'b0, q_zero}, 4'h1);
      tick("fall2");
      check1("zero_fall", {3'b0, q_zero}, 4'h0);

      // Mid-flight reset discards the in-flight value.
      d_zero = 1'b1;
      tick("flight");
      set_ctl(1'b1, 1'b0);
      check1("midrst_zero", {3'b0, q_zero}, 4'h0);
      check1("midrst_wide", q_wide, 4'h0);
      set_ctl(1'b0, 1'b0);
      tick("post1");
      check1("post_rst_e1", {3'b0, q_zero}, 4'h0);
      tick("post2");
      check1("post_rst_e2", {3'b0, q_zero}, 4'h1);

      // Scan shift gates reset off; data keeps flowing.
      set_ctl(1'b0, 1'b1);
      set_ctl(1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         d_zero = ~d_zero;
         d_one  = 1'($urandom);
         d_wide = 4'($urandom);
         tick("scan");
      end
      set_ctl(1'b1, 1'b0);
      check1("scan_drop_zero", {3'b0, q_zero}, 4'h0);
      check1("scan_drop_one", {3'b0, q_one}, 4'h1);

      // Random traffic with occasional reset and scan activity.
      set_ctl(1'b0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         int r;
         d_zero = 1'($urandom);
         d_one  = 1'($urandom);
         d_wide = 4'($urandom);
         r = int'($urandom_range(0, 15));
         if (r == 0)      set_ctl(1'b1, scan);
         else if (r <= 2) set_ctl(1'b0, scan);
         else if (r == 3) set_ctl(rst, ~scan);
         tick("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
